// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared constants and types for the round-robin button scan controller.
//   MAX_BUTTONS  : width of the CPU read data bus, and the largest supported
//                  button count.
//   ADDR_STATE   : read address of the debounced-level register.
//   ADDR_EVENTS  : read address of the sticky press-event register.
//                  Reading it clears the returned bits.
//   scan_state_e : scan FSM states.
// ---------------------------------------------------------------------------
package button_pkg;

    localparam int unsigned MAX_BUTTONS = 16;

    localparam logic ADDR_STATE  = 1'b0;
    localparam logic ADDR_EVENTS = 1'b1;

    typedef enum logic {
        INIT,
        SCAN
    } scan_state_e;

endpackage

// File: rtl/button_sync.sv
// ---------------------------------------------------------------------------
// button_sync
// Two-flop synchronizer for a vector of asynchronous inputs.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset; both stages clear to 0
//   d_i   : raw asynchronous inputs
//   q_o   : synchronized inputs, two cycles of latency
// ---------------------------------------------------------------------------
module button_sync #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_scan_controller.sv
// ---------------------------------------------------------------------------
// button_scan_controller
// A single debounce datapath is shared round-robin across NUM_BUTTONS
// synchronized button inputs. Each button has its own counter in a small
// register array. The block keeps a debounced level and a sticky press event
// for every button. A CPU reads them through a two-register port.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   buttons_in : raw button pins, 1 = pressed
//   rd_en      : one-cycle read strobe
//   rd_addr    : 0 = STATE, 1 = EVENTS (clear-on-read)
//   rd_data    : registered read data, zero-extended to 16 bits
//   rd_valid   : high the cycle after an accepted rd_en
//   irq        : registered OR of all event bits
// ---------------------------------------------------------------------------
module button_scan_controller
    import button_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS   = 16,
    parameter int unsigned COUNTER_SIZE  = 8,
    parameter int unsigned COUNTER_VALUE = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    input  logic                   rd_en,
    input  logic                   rd_addr,
    output logic [MAX_BUTTONS-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   irq
);

    localparam int unsigned IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [COUNTER_SIZE-1:0] CNT_LAST = COUNTER_SIZE'(COUNTER_VALUE - 1);

    logic [NUM_BUTTONS-1:0]  sync;

    scan_state_e             fsm_q, fsm_d;
    logic                    scan_en;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [COUNTER_SIZE-1:0] cnt_q [NUM_BUTTONS];
    logic [COUNTER_SIZE-1:0] cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0]  level_q, level_d;
    logic [NUM_BUTTONS-1:0]  events_q, events_d;
    logic [NUM_BUTTONS-1:0]  event_set, event_clr;

    logic [MAX_BUTTONS-1:0]  rd_data_q, rd_data_d;
    logic                    rd_valid_q;
    logic                    irq_q;

    button_sync #(
        .WIDTH (NUM_BUTTONS)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (buttons_in),
        .q_o   (sync)
    );

    // -------------------------------------------------------------------
    // Scan FSM
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q <= INIT;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            INIT:    fsm_d = SCAN;
            SCAN:    fsm_d = SCAN;
            default: fsm_d = INIT;
        endcase
    end

    always_comb begin
        scan_en = (fsm_q == SCAN);
    end

    // -------------------------------------------------------------------
    // Shared debounce slot: one button index is updated per cycle
    // -------------------------------------------------------------------
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        event_set = '0;
        if (scan_en) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (sync[idx_q] == level_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] == CNT_LAST) begin
                level_d[idx_q]   = sync[idx_q];
                cnt_d[idx_q]     = '0;
                event_set[idx_q] = sync[idx_q];
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------
    // Read port. An EVENTS read clears only the bits it returned. A bit
    // set by the scan in the same cycle is ORed in after the clear, so it
    // is kept for the next read.
    // -------------------------------------------------------------------
    always_comb begin
        rd_data_d = rd_data_q;
        event_clr = '0;
        if (rd_en) begin
            if (rd_addr == ADDR_EVENTS) begin
                rd_data_d = MAX_BUTTONS'(events_q);
                event_clr = events_q;
            end else begin
                rd_data_d = MAX_BUTTONS'(level_q);
            end
        end
        events_d = (events_q & ~event_clr) | event_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= '0;
            cnt_q      <= '{default: '0};
            level_q    <= '0;
            events_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            events_q   <= events_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            irq_q      <= |events_q;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule
